// File: rtl/ccd_capture_ctrl.sv
// ccd_capture_ctrl
// Capture controller for a CCD/CMOS camera front end. It turns a continuous-run
// level (iRUN) or a snapshot request edge (iSNAP) into one-cycle start/end
// pulses for the capture datapath. Frame boundaries are taken from iFVAL edges.
//
// Optional feature: define CCD_CTRL_TIMEOUT_EN to add an ARM-state timeout.
// With the timeout enabled, a snapshot that sees no frame start within
// TIMEOUT_CYC cycles is aborted and flagged on oTIMEOUT.
// With it disabled (the default), ARM waits indefinitely and oTIMEOUT is 0.
module ccd_capture_ctrl #(
    parameter int SNAP_FRAMES = 1,
    parameter int TIMEOUT_CYC = 5000000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iFVAL,
    input  logic       iRUN,
    input  logic       iSNAP,
    output logic       oSTART,
    output logic       oEND,
    output logic       oBUSY,
    output logic [2:0] oSTATE,
    output logic [7:0] oFRAMES,
    output logic       oTIMEOUT
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        CAPT = 3'd2,
        CONT = 3'd3,
        STOP = 3'd4
    } state_t;

    localparam logic [7:0]  SNAP_LAST = 8'(SNAP_FRAMES);
    localparam logic [23:0] TO_LAST   = 24'(TIMEOUT_CYC - 1);

    state_t state;
    logic   fvalD;
    logic   snapD;
    logic   fvalRise;
    logic   fvalFall;
    logic   snapEdge;
    logic   timeoutHit;

    // Delayed copies of the frame-valid and snapshot inputs for edge detection
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            fvalD <= 1'b0;
            snapD <= 1'b0;
        end else begin
            fvalD <= iFVAL;
            snapD <= iSNAP;
        end
    end

    assign fvalRise = !fvalD && iFVAL;
    assign fvalFall = fvalD && !iFVAL;
    assign snapEdge = !snapD && iSNAP;

`ifdef CCD_CTRL_TIMEOUT_EN
    logic [23:0] armCnt;

    // Count cycles spent in ARM; the count sits at zero everywhere else, so it
    // always starts from zero on ARM entry
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            armCnt <= '0;
        end else if (state == ARM) begin
            armCnt <= armCnt + 24'd1;
        end else begin
            armCnt <= '0;
        end
    end

    assign timeoutHit = (state == ARM) && (armCnt == TO_LAST);

    // Sticky abort flag: cleared by an accepted request, set by a timeout that
    // was not rescued by a frame start in the same cycle
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oTIMEOUT <= 1'b0;
        end else if ((state == IDLE) && (iRUN || snapEdge)) begin
            oTIMEOUT <= 1'b0;
        end else if (timeoutHit && !fvalRise) begin
            oTIMEOUT <= 1'b1;
        end
    end
`else
    logic [23:0] unusedTimeoutLast;
    assign unusedTimeoutLast = TO_LAST;
    assign timeoutHit        = 1'b0;
    assign oTIMEOUT          = 1'b0;
`endif

    // Session FSM with registered start/end/busy pulses and frame counter
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state   <= IDLE;
            oSTART  <= 1'b0;
            oEND    <= 1'b0;
            oBUSY   <= 1'b0;
            oFRAMES <= 8'd0;
        end else begin
            oSTART <= 1'b0;
            oEND   <= 1'b0;
            case (state)
                IDLE: begin
                    // Continuous run wins over a simultaneous snapshot edge
                    if (iRUN) begin
                        state   <= CONT;
                        oSTART  <= 1'b1;
                        oBUSY   <= 1'b1;
                        oFRAMES <= 8'd0;
                    end else if (snapEdge) begin
                        state   <= ARM;
                        oSTART  <= 1'b1;
                        oBUSY   <= 1'b1;
                        oFRAMES <= 8'd0;
                    end
                end
                ARM: begin
                    // A frame start beats a timeout landing in the same cycle
                    if (fvalRise) begin
                        state <= CAPT;
                    end else if (timeoutHit) begin
                        state <= STOP;
                        oEND  <= 1'b1;
                    end
                end
                CAPT: begin
                    if (fvalFall) begin
                        oFRAMES <= oFRAMES + 8'd1;
                        if (oFRAMES == SNAP_LAST - 8'd1) begin
                            state <= STOP;
                            oEND  <= 1'b1;
                        end
                    end
                end
                CONT: begin
                    if (fvalFall && (oFRAMES != 8'hFF)) begin
                        oFRAMES <= oFRAMES + 8'd1;
                    end
                    // The frame in flight is finished by the datapath itself
                    if (!iRUN) begin
                        state <= STOP;
                        oEND  <= 1'b1;
                    end
                end
                STOP: begin
                    state <= IDLE;
                    oBUSY <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    oBUSY <= 1'b0;
                end
            endcase
        end
    end

    assign oSTATE = state;

endmodule

// File: doc/ccd_capture_ctrl.md
CCD_CAPTURE_CTRL -- requirements
Module: ccd_capture_ctrl

Interface
REQ-001 SHALL have parameter SNAP_FRAMES, default 1, frames captured per snapshot request (legal 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 5000000, ARM-state cycles allowed before abort (24-bit).
REQ-003 iCLK  in  1  pixel clock, same domain as the capture datapath; all logic on rising edge.
REQ-004 iRST  in  1  reset, asynchronous, active-low.
REQ-005 iFVAL  in  1  camera frame-valid, synchronous to iCLK.
REQ-006 iRUN  in  1  level; high requests continuous capture.
REQ-007 iSNAP  in  1  snapshot request; only its rising edge is used.
REQ-008 oSTART  out  1  one-cycle pulse to the capture datapath start input.
REQ-009 oEND  out  1  one-cycle pulse to the capture datapath end input.
REQ-010 oBUSY  out  1  high whenever state is not IDLE.
REQ-011 oSTATE  out  3  current state encoding: IDLE=0, ARM=1, CAPT=2, CONT=3, STOP=4.
REQ-012 oFRAMES  out  8  frames completed in the current session.
REQ-013 oTIMEOUT  out  1  sticky flag; last snapshot aborted for lack of a frame start.

Function
REQ-014 Registered copies of iFVAL and iSNAP SHALL be used for edge detection: FVAL rise = !fval_d & iFVAL, FVAL fall = fval_d & !iFVAL, snap edge = !snap_d & iSNAP.
REQ-015 IDLE: iRUN high -> CONT. Else snap edge -> ARM. Either transition clears oFRAMES and oTIMEOUT.
REQ-016 iRUN high and snap edge in the same IDLE cycle -> CONT. The snap edge is dropped.
REQ-017 Snap edges outside IDLE SHALL be ignored, not queued.
REQ-018 oSTART SHALL be high exactly during the first cycle spent in ARM or CONT (one cycle after the request edge).
REQ-019 ARM: FVAL rise -> CAPT. If iFVAL is already high on entry, wait for the next rise.
REQ-020 ARM timeout counter: cleared on ARM entry, increments each ARM cycle. Reaching TIMEOUT_CYC-1 -> STOP and set oTIMEOUT.
REQ-021 CAPT: each FVAL fall increments oFRAMES. The fall that makes oFRAMES equal SNAP_FRAMES also moves to STOP in the same cycle. iRUN is ignored in CAPT.
REQ-022 CONT: each FVAL fall increments oFRAMES, saturating at 255. iRUN low -> STOP immediately (the frame in flight completes in the datapath).
REQ-023 A FVAL rise in the same cycle as the ARM timeout terminal count SHALL take CAPT; the timeout is not flagged.
REQ-024 STOP SHALL last one cycle with oEND high, then return to IDLE. oSTART and oEND are never high together.
REQ-025 oFRAMES and oTIMEOUT SHALL hold their values in IDLE until the next accepted request.

Reset
REQ-026 iRST low SHALL immediately force: state IDLE, oSTART=0, oEND=0, oBUSY=0, oSTATE=0, oFRAMES=0, oTIMEOUT=0, edge registers 0, timeout counter 0.
REQ-027 Reset mid-session SHALL abandon the session without issuing oEND.
REQ-028 After reset release, a level already high on iSNAP SHALL register as an edge. iRUN high SHALL enter CONT on the first clock.

Configuration
REQ-029 Macro CCD_CTRL_TIMEOUT_EN defined: timeout counter and REQ-020/REQ-023 present.
REQ-030 Macro CCD_CTRL_TIMEOUT_EN undefined: no counter logic, ARM waits indefinitely for a FVAL rise, oTIMEOUT tied to 0.

Verification
REQ-031 SNAP_FRAMES=2. One snap pulse, then 3 frames of iFVAL -> oSTART 1 cycle after the edge; oFRAMES 1, then 2; oEND on the cycle after the 2nd FVAL fall; 3rd frame ignored; oBUSY low afterwards.
REQ-032 iRUN high for 4 frames, then low mid-frame 5 -> CONT, oFRAMES=4, STOP/oEND the cycle after iRUN falls, IDLE next cycle.
REQ-033 TIMEOUT_CYC=16, macro defined. Snap with iFVAL held low -> STOP after 16 ARM cycles, oTIMEOUT=1, oFRAMES=0. Next snap clears oTIMEOUT.
REQ-034 iRUN and snap edge in the same IDLE cycle -> oSTATE=3. A 2nd snap during CONT has no effect.
REQ-035 iRST asserted in CAPT with oFRAMES=1 -> all outputs 0 asynchronously; no oEND pulse.
REQ-036 Snap armed while iFVAL already high -> stays ARM until iFVAL falls and rises again, then CAPT.
